// File: rtl/pipe_skid_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pipe_skid_reg : 2-entry valid/ready skid buffer with flush, registered ready |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+

module pipe_skid_dff #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (!rst) q <= RST_BIT;
    else      q <= d;
  end
endmodule

module pipe_skid_reg #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             w_push, w_pop;
  logic             w_main_en, w_main_from_skid, w_skid_en;

  // Ready is decoded from state alone so out_ready never reaches in_ready.
  assign in_ready  = (state_q != S_FULL) & rst;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign count     = count_q;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_comb begin
    state_d          = state_q;
    w_main_en        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_en        = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_push) begin
            state_d   = S_ONE;
            w_main_en = 1'b1;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            w_main_en = 1'b1;
          end else if (w_push) begin
            state_d   = S_FULL;
            w_skid_en = 1'b1;
          end else if (w_pop) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            state_d          = S_ONE;
            w_main_en        = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    count_d = 2'd0;
    case (state_d)
      S_ONE:   count_d = 2'd1;
      S_FULL:  count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign main_d = w_main_en ? (w_main_from_skid ? skid_q : in_data) : main_q;
  assign skid_d = w_skid_en ? in_data : skid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pipe_skid_dff #(.RST_BIT(RST_VAL[i])) u_main_dff (
      .clk (clk),
      .rst (rst),
      .d   (main_d[i]),
      .q   (main_q[i])
    );
    pipe_skid_dff #(.RST_BIT(RST_VAL[i])) u_skid_dff (
      .clk (clk),
      .rst (rst),
      .d   (skid_d[i]),
      .q   (skid_q[i])
    );
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the payload width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter RST_VAL, default {WIDTH{1'b0}}, giving the out_data value after reset.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous and active-low (rst = 0 at a rising clk edge resets the block).
REQ-005 The block SHALL have port flush  input  1  discards all buffered entries.
REQ-006 The block SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 The block SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 The block SHALL have port in_ready  output  1  block can accept a payload this cycle.
REQ-009 The block SHALL have port out_valid  output  1  out_data holds a valid payload.
REQ-010 The block SHALL have port out_data  output  WIDTH  head payload.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts the payload.
REQ-012 The block SHALL have port count  output  2  number of buffered entries (0..2).

Function
REQ-013 The block SHALL hold a 2-entry buffer: MAIN (drives out_data) and SKID, with states EMPTY (count 0), ONE (count 1) and FULL (count 2).
REQ-014 A push SHALL occur on a cycle with in_valid & in_ready; a pop SHALL occur on a cycle with out_valid & out_ready.
REQ-015 in_ready SHALL be (state != FULL) & rst, decoded from state only, with no combinational path from out_ready.
REQ-016 out_valid SHALL be (state != EMPTY).
REQ-017 EMPTY with push: next state ONE, and MAIN SHALL take in_data; latency from in_data to out_data is 1 cycle.
REQ-018 ONE with push and no pop: next state FULL, and SKID SHALL take in_data.
REQ-019 ONE with push and pop: state SHALL stay ONE, and MAIN SHALL take in_data.
REQ-020 ONE with pop and no push: next state EMPTY.
REQ-021 FULL with pop: next state ONE, and MAIN SHALL take SKID; no push is possible in FULL.
REQ-022 Payloads SHALL leave in arrival order, with none lost or duplicated.
REQ-023 While out_valid = 1 and out_ready = 0, out_data SHALL stay stable.
REQ-024 In EMPTY, out_data SHALL hold its last value (RST_VAL if no payload has been accepted since reset).
REQ-025 flush = 1 at a rising edge SHALL force the next state to EMPTY, overriding any push or pop that cycle; a payload offered on the flush cycle is dropped.
REQ-026 Flush SHALL NOT change out_data.
REQ-027 count SHALL equal 0, 1 or 2 for EMPTY, ONE or FULL respectively, and is registered.
REQ-028 All WIDTH bits SHALL be stored with a per-bit dff primitive plus enable muxing, with no clock gating.

Reset
REQ-029 On rst = 0 at a rising clk edge, the next state SHALL be EMPTY, count = 0, out_valid = 0, out_data = RST_VAL, and SKID = RST_VAL.
REQ-030 While rst = 0, in_ready SHALL be 0 and push/pop/flush SHALL be ignored; reset overrides flush.
REQ-031 Reset asserted in FULL or ONE SHALL discard all entries; the first cycle after rst returns to 1 shows in_ready = 1 and out_valid = 0.

Verification
REQ-032 Reset then idle: rst low 2 cycles -> count = 0, out_valid = 0, out_data = RST_VAL, in_ready = 1 after release.
REQ-033 Streaming with WIDTH=16: push 0x1111, 0x2222, 0x3333 on consecutive cycles with out_ready = 1 -> out_data 0x1111, 0x2222, 0x3333 on the following consecutive cycles, count stays 1.
REQ-034 Backpressure: out_ready = 0, push 0xAAAA then 0xBBBB -> count = 2, in_ready = 0, out_data = 0xAAAA stable; raise out_ready -> 0xAAAA then 0xBBBB, count 2 -> 1 -> 0.
REQ-035 Flush in FULL with in_valid = 1 and in_data = 0xCCCC -> next cycle count = 0, out_valid = 0, in_ready = 1; 0xCCCC is never output.
REQ-036 Reset mid-operation in FULL -> next cycle EMPTY, out_data = RST_VAL; then push 0x0042 -> out_data = 0x0042 one cycle later.
REQ-037 Randomised valid/ready/flush over 10k cycles with WIDTH=8 and WIDTH=32 -> output sequence matches a reference queue model, and there is no transfer while in_ready = 0.
